// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline-side and data-cache-side signals of the MEM-stage access
// controller, bundled into one interface.
//   master : the controller. It consumes EX/MEM fields, snoop and cache responses, and
//            drives the cache request, stall, load data, SC result, halt and counters.
//   slave  : the environment. This is the EX/MEM register, the coherence path and the
//            data cache.
interface mem_access_ctrl_if;
  // EX/MEM fields
  logic        dREN_i;
  logic        dWEN_i;
  logic        ll_i;
  logic        sc_i;
  logic        halt_i;
  logic [31:0] aluout_i;
  logic [31:0] rdat2_i;
  // coherence invalidation
  logic        snoop_inval_i;
  logic [31:0] snoop_addr_i;
  // data cache
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  // pipeline / status
  logic        stall_o;
  logic [31:0] ldata_o;
  logic        sc_result_o;
  logic        halt_o;
  logic [31:0] access_cnt_o;
  logic [31:0] stall_cnt_o;

  modport master (
    input  dREN_i, dWEN_i, ll_i, sc_i, halt_i, aluout_i, rdat2_i,
    input  snoop_inval_i, snoop_addr_i, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    output stall_o, ldata_o, sc_result_o, halt_o, access_cnt_o, stall_cnt_o
  );

  modport slave (
    output dREN_i, dWEN_i, ll_i, sc_i, halt_i, aluout_i, rdat2_i,
    output snoop_inval_i, snoop_addr_i, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  stall_o, ldata_o, sc_result_o, halt_o, access_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access controller that sits after the EX/MEM register.
// It turns a load or store into a data-cache request and holds that request stable until
// dhit. It stalls the pipeline while the request is outstanding. It captures load data
// for MEM/WB and latches a sticky halt.
//
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - mem_access_ctrl_if.master. It carries the EX/MEM fields (dREN_i, dWEN_i, ll_i,
//          sc_i, halt_i, aluout_i, rdat2_i), the snoop inputs and the cache handshake
//          (dhit, dmemload, dmemREN, dmemWEN, dmemaddr, dmemstore). It also carries the
//          outputs stall_o, ldata_o, sc_result_o, halt_o, access_cnt_o and stall_cnt_o.
//
// Build option:
//   LLSC_EN - when defined, the LL/SC link register, the SC-fail path and the snoop
//             invalidation are built. When undefined, LL is a plain load, SC is a plain
//             store and sc_result_o is tied to 1.
module mem_access_ctrl (
  input  logic                 CLK,
  input  logic                 RST,
  mem_access_ctrl_if.master    bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]  state_q, state_d;

  // request held while waiting for dhit
  logic        ren_q, wen_q, halt_q;
  logic [31:0] addr_q, store_q;

  logic [31:0] ldata_q;
  logic [31:0] access_q, stall_cnt_q;

  logic        req, scfail, issue, in_wait, active, done, stall;
  logic        cur_ren, cur_wen;
  logic [31:0] cur_addr, cur_store;

  assign req     = bus.dREN_i | bus.dWEN_i;
  assign in_wait = (state_q == WAIT);
  // no new request is presented while reset is held, so requests drop asynchronously
  assign issue   = (state_q == IDLE) & req & ~scfail & ~RST;
  assign active  = issue | in_wait;
  assign done    = active & bus.dhit;
  assign stall   = active & ~bus.dhit;

  assign cur_ren   = in_wait ? ren_q   : bus.dREN_i;
  assign cur_wen   = in_wait ? wen_q   : bus.dWEN_i;
  assign cur_addr  = in_wait ? addr_q  : bus.aluout_i;
  assign cur_store = in_wait ? store_q : bus.rdat2_i;

  always_comb begin
    bus.dmemREN   = active & cur_ren;
    bus.dmemWEN   = active & cur_wen;
    bus.dmemaddr  = active ? cur_addr  : 32'h0;
    bus.dmemstore = active ? cur_store : 32'h0;
    bus.stall_o   = stall;
    bus.ldata_o   = bus.dhit ? bus.dmemload : ldata_q;
    bus.halt_o    = (state_q == HALT);
    bus.access_cnt_o = access_q;
    bus.stall_cnt_o  = stall_cnt_q;
  end

  // A request that completes alongside halt_i finishes first and then halts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue & ~bus.dhit) state_d = WAIT;
        else if (bus.halt_i)   state_d = HALT;
      end
      WAIT: begin
        if (bus.dhit) state_d = halt_q ? HALT : IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      halt_q      <= 1'b0;
      addr_q      <= 32'h0;
      store_q     <= 32'h0;
      ldata_q     <= 32'h0;
      access_q    <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        ren_q   <= bus.dREN_i;
        wen_q   <= bus.dWEN_i;
        halt_q  <= bus.halt_i;
        addr_q  <= bus.aluout_i;
        store_q <= bus.rdat2_i;
      end
      if (done & cur_ren) ldata_q <= bus.dmemload;
      if (done && access_q != 32'hFFFF_FFFF) access_q <= access_q + 32'd1;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

`ifdef LLSC_EN
  logic        ll_q, sc_q;
  logic        cur_ll, cur_sc;
  logic        link_valid_q, link_valid_d;
  logic [31:2] link_addr_q, link_addr_d;
  logic        sc_res_q, sc_res_d;
  logic        snoop_hit, scfail_done, ll_snooped;
  logic        unused_llsc;

  assign cur_ll = in_wait ? ll_q : bus.ll_i;
  assign cur_sc = in_wait ? sc_q : bus.sc_i;

  assign snoop_hit = bus.snoop_inval_i & (bus.snoop_addr_i[31:2] == link_addr_q);
  // The snoop check sits inside the success term, so a snoop in the SC check cycle wins.
  assign scfail = bus.sc_i & bus.dWEN_i &
                  ~(link_valid_q & (link_addr_q == bus.aluout_i[31:2]) & ~snoop_hit);
  // SC failure resolves without the cache. It is only meaningful from IDLE.
  assign scfail_done = (state_q == IDLE) & scfail;
  // An LL whose word is invalidated in its completion cycle must not set the link.
  assign ll_snooped  = bus.snoop_inval_i & (bus.snoop_addr_i[31:2] == cur_addr[31:2]);
  assign unused_llsc = ^bus.snoop_addr_i[1:0];

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    sc_res_d     = sc_res_q;
    if (done & cur_wen & (cur_addr[31:2] == link_addr_q)) link_valid_d = 1'b0;
    if (done & cur_wen & cur_sc) begin
      link_valid_d = 1'b0;
      sc_res_d     = 1'b1;
    end
    if (scfail_done) begin
      link_valid_d = 1'b0;
      sc_res_d     = 1'b0;
    end
    if (snoop_hit) link_valid_d = 1'b0;
    if (done & cur_ren & cur_ll) begin
      if (ll_snooped) begin
        link_valid_d = 1'b0;
      end else begin
        link_valid_d = 1'b1;
        link_addr_d  = cur_addr[31:2];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ll_q         <= 1'b0;
      sc_q         <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      sc_res_q     <= 1'b0;
    end else begin
      if (issue) begin
        ll_q <= bus.ll_i;
        sc_q <= bus.sc_i;
      end
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      sc_res_q     <= sc_res_d;
    end
  end

  assign bus.sc_result_o = sc_res_q;
`else
  logic unused_llsc;

  assign scfail          = 1'b0;
  assign bus.sc_result_o = 1'b1;
  assign unused_llsc     = ^{bus.ll_i, bus.sc_i, bus.snoop_inval_i, bus.snoop_addr_i};
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a per-cycle vector table for load miss/store hit,
// then hand sequences for LL/SC, snoop, reset during WAIT and halt.
module tb_mem_access_ctrl;

`ifdef LLSC_EN
  localparam bit Llsc = 1'b1;
`else
  localparam bit Llsc = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        dren;
    logic        dwen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dhit;
    logic [31:0] mload;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_stall;
    logic [31:0] e_ldata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic dren, input logic dwen, input logic ll, input logic sc,
                       input logic halt, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic dhit, input logic [31:0] mload);
    bus.dREN_i   = dren;
    bus.dWEN_i   = dwen;
    bus.ll_i     = ll;
    bus.sc_i     = sc;
    bus.halt_i   = halt;
    bus.aluout_i = addr;
    bus.rdat2_i  = wdata;
    bus.dhit     = dhit;
    bus.dmemload = mload;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.snoop_inval_i = 1'b0;
    bus.snoop_addr_i  = 32'h0;
    idle();

    //            dren  dwen  addr        wdata       dhit  mload         ren   wen   eaddr       estore      stall ldata
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'hAAAA, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'hAAAA, 1'b1, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h999, 32'hBBBB, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'hAAAA, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'hAAAA, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'hAAAA, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h100, 32'hAAAA, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h100, 32'hAAAA, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b1, 32'h200, 32'h1234, 1'b1, 32'h5555,     1'b0, 1'b1, 32'h200, 32'h1234, 1'b0, 32'h5555};
    vecs[6] = '{1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 32'hDEADBEEF};

    // reset values
    RST = 1'b1;
    #3;
    chk("rst_ren",   {31'h0, bus.dmemREN}, 32'h0);
    chk("rst_wen",   {31'h0, bus.dmemWEN}, 32'h0);
    chk("rst_stall", {31'h0, bus.stall_o}, 32'h0);
    chk("rst_halt",  {31'h0, bus.halt_o},  32'h0);
    chk("rst_ldata", bus.ldata_o, 32'h0);
    chk("rst_acnt",  bus.access_cnt_o, 32'h0);
    chk("rst_scnt",  bus.stall_cnt_o,  32'h0);
    chk("rst_scres", {31'h0, bus.sc_result_o}, Llsc ? 32'h0 : 32'h1);
    #9;
    RST = 1'b0;
    cyc();

    // load miss (3 stall cycles) then store hit
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].dren, vecs[i].dwen, 1'b0, 1'b0, 1'b0, vecs[i].addr, vecs[i].wdata,
            vecs[i].dhit, vecs[i].mload);
      #2;
      chk($sformatf("v%0d_ren", i),   {31'h0, bus.dmemREN}, {31'h0, vecs[i].e_ren});
      chk($sformatf("v%0d_wen", i),   {31'h0, bus.dmemWEN}, {31'h0, vecs[i].e_wen});
      chk($sformatf("v%0d_addr", i),  bus.dmemaddr,  vecs[i].e_addr);
      chk($sformatf("v%0d_store", i), bus.dmemstore, vecs[i].e_store);
      chk($sformatf("v%0d_stall", i), {31'h0, bus.stall_o}, {31'h0, vecs[i].e_stall});
      chk($sformatf("v%0d_ldata", i), bus.ldata_o, vecs[i].e_ldata);
      cyc();
    end
    chk("tbl_acnt", bus.access_cnt_o, 32'd2);
    chk("tbl_scnt", bus.stall_cnt_o,  32'd3);

    // LL then SC: SC succeeds and writes
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 32'h11);
    #2 chk("ll_ren", {31'h0, bus.dmemREN}, 32'h1);
    cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h7, 1'b1, 32'h0);
    #2;
    chk("sc1_wen",   {31'h0, bus.dmemWEN}, 32'h1);
    chk("sc1_stall", {31'h0, bus.stall_o}, 32'h0);
    cyc();
    idle();
    #2 chk("sc1_res", {31'h0, bus.sc_result_o}, 32'h1);
    // second SC: link consumed, no request
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h8, 1'b1, 32'h0);
    #2;
    chk("sc2_wen",   {31'h0, bus.dmemWEN}, Llsc ? 32'h0 : 32'h1);
    chk("sc2_stall", {31'h0, bus.stall_o}, 32'h0);
    cyc();
    idle();
    #2 chk("sc2_res", {31'h0, bus.sc_result_o}, Llsc ? 32'h0 : 32'h1);

    // LL then SC with a same-cycle snoop to the link word
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 32'h22);
    cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h9, 1'b1, 32'h0);
    bus.snoop_inval_i = 1'b1;
    bus.snoop_addr_i  = 32'h300;
    #2;
    chk("sc3_wen",   {31'h0, bus.dmemWEN}, Llsc ? 32'h0 : 32'h1);
    chk("sc3_stall", {31'h0, bus.stall_o}, 32'h0);
    cyc();
    bus.snoop_inval_i = 1'b0;
    idle();
    #2;
    chk("sc3_res",  {31'h0, bus.sc_result_o}, Llsc ? 32'h0 : 32'h1);
    chk("sc3_wen2", {31'h0, bus.dmemWEN}, 32'h0);
    chk("llsc_acnt", bus.access_cnt_o, Llsc ? 32'd5 : 32'd7);
    cyc();

    // reset during WAIT
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    cyc();
    idle();
    #2;
    chk("wait_hold_ren", {31'h0, bus.dmemREN}, 32'h1);
    chk("wait_addr",     bus.dmemaddr, 32'h400);
    RST = 1'b1;
    #1;
    chk("mrst_ren",   {31'h0, bus.dmemREN}, 32'h0);
    chk("mrst_addr",  bus.dmemaddr, 32'h0);
    chk("mrst_stall", {31'h0, bus.stall_o}, 32'h0);
    chk("mrst_acnt",  bus.access_cnt_o, 32'h0);
    chk("mrst_scnt",  bus.stall_cnt_o, 32'h0);
    chk("mrst_ldata", bus.ldata_o, 32'h0);
    cyc();
    RST = 1'b0;
    #2 chk("post_rst_idle_ren", {31'h0, bus.dmemREN}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h99);
    #2 chk("post_rst_stall", {31'h0, bus.stall_o}, 32'h0);
    cyc();
    idle();
    #2;
    chk("post_rst_acnt",  bus.access_cnt_o, 32'd1);
    chk("post_rst_ldata", bus.ldata_o, 32'h99);

    // halt with no request
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
    cyc();
    idle();
    #2 chk("halt_set", {31'h0, bus.halt_o}, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0);
    #2;
    chk("halt_noreq_ren",   {31'h0, bus.dmemREN}, 32'h0);
    chk("halt_noreq_stall", {31'h0, bus.stall_o}, 32'h0);
    cyc();
    #2;
    chk("halt_sticky", {31'h0, bus.halt_o}, 32'h1);
    chk("halt_ren2",   {31'h0, bus.dmemREN}, 32'h0);

    // halt together with a request: access completes, then halt
    idle();
    pulse_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 32'h0, 1'b1, 32'h77);
    #2 chk("hreq_ren", {31'h0, bus.dmemREN}, 32'h1);
    cyc();
    idle();
    #2;
    chk("hreq_halt",  {31'h0, bus.halt_o}, 32'h1);
    chk("hreq_ldata", bus.ldata_o, 32'h77);
    chk("hreq_acnt",  bus.access_cnt_o, 32'd1);
    pulse_reset();
    chk("halt_cleared", {31'h0, bus.halt_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
